// File: rtl/dp_ctrl_pkg.sv
// Shared encodings for the datapath controller: FSM states, opcode and op constants.
package dp_ctrl_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned REG_W   = 3;
  localparam int unsigned IMM_W   = 8;

  typedef enum logic [2:0] {
    WAIT      = 3'd0,
    DECODE    = 3'd1,
    WRITE_IMM = 3'd2,
    GET_A     = 3'd3,
    GET_B     = 3'd4,
    EXEC      = 3'd5,
    WRITE_REG = 3'd6
  } state_e;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;

  // ALU ops that write a result back to Rd (everything except CMP)
  function automatic logic alu_writes_rd(input logic [1:0] op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_MVN);
  endfunction

endpackage

// File: rtl/instr_dec.sv
// Combinational instruction decoder: splits IR into fields and classifies the instruction.
module instr_dec
  import dp_ctrl_pkg::*;
(
  input  logic [INSTR_W-1:0] ir,
  output logic [1:0]         op,
  output logic [REG_W-1:0]   rn,
  output logic [REG_W-1:0]   rd,
  output logic [1:0]         sh,
  output logic [REG_W-1:0]   rm,
  output logic [INSTR_W-1:0] imm16,
  output logic               is_mov_imm,
  output logic               is_mov_reg,
  output logic               is_alu,
  output logic               is_cmp,
  output logic               is_alu_wr
);

  logic [2:0]       opcode;
  logic [IMM_W-1:0] imm8;

  // Field extraction, imm8 sign extension and instruction class flags
  always_comb begin
    opcode     = ir[15:13];
    op         = ir[12:11];
    rn         = ir[10:8];
    rd         = ir[7:5];
    sh         = ir[4:3];
    rm         = ir[2:0];
    imm8       = ir[7:0];
    imm16      = {{(INSTR_W-IMM_W){imm8[IMM_W-1]}}, imm8};
    is_mov_imm = (opcode == OPC_MOV) && (op == OP_MOV_IMM);
    is_mov_reg = (opcode == OPC_MOV) && (op == OP_MOV_REG);
    is_alu     = (opcode == OPC_ALU);
    is_cmp     = is_alu && (op == OP_CMP);
    is_alu_wr  = is_alu && alu_writes_rd(op);
  end

endmodule

// File: rtl/dp_controller.sv
// Datapath controller: instruction register plus a Moore FSM sequencing register-file and ALU strobes.
module dp_controller
  import dp_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               s,
  input  logic               load,
  input  logic [INSTR_W-1:0] in,
  output logic               w,
  output logic [REG_W-1:0]   readnum,
  output logic [REG_W-1:0]   writenum,
  output logic               write,
  output logic               loada,
  output logic               loadb,
  output logic               loadc,
  output logic               loads,
  output logic               asel,
  output logic               bsel,
  output logic               vsel,
  output logic [1:0]         shift,
  output logic [1:0]         ALUop,
  output logic [INSTR_W-1:0] datapath_in
);

  state_e             state_q, state_d;
  logic [INSTR_W-1:0] ir_q, ir_d;

  logic [1:0]         op;
  logic [REG_W-1:0]   rn, rd, rm;
  logic [1:0]         sh;
  logic [INSTR_W-1:0] imm16;
  logic               is_mov_imm, is_mov_reg, is_alu, is_cmp, is_alu_wr;

  instr_dec u_instr_dec (
    .ir         (ir_q),
    .op         (op),
    .rn         (rn),
    .rd         (rd),
    .sh         (sh),
    .rm         (rm),
    .imm16      (imm16),
    .is_mov_imm (is_mov_imm),
    .is_mov_reg (is_mov_reg),
    .is_alu     (is_alu),
    .is_cmp     (is_cmp),
    .is_alu_wr  (is_alu_wr)
  );

  // State and instruction register; reset aborts any instruction in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= WAIT;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  // IR capture is unconditional on load; software only loads while idle
  always_comb begin
    ir_d = ir_q;
    if (load) ir_d = in;
  end

  // Next-state sequencing
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WAIT:      if (s) state_d = DECODE;
      DECODE: begin
        if (is_mov_imm)      state_d = WRITE_IMM;
        else if (is_mov_reg) state_d = GET_B;
        else if (is_alu)     state_d = GET_A;
        else                 state_d = WAIT;
      end
      WRITE_IMM: state_d = WAIT;
      GET_A:     state_d = GET_B;
      GET_B:     state_d = EXEC;
      EXEC:      state_d = (is_cmp) ? WAIT : WRITE_REG;
      WRITE_REG: state_d = WAIT;
      default:   state_d = WAIT;
    endcase
  end

  // Moore control decode from registered state and IR; undriven strobes stay low
  always_comb begin
    w           = 1'b0;
    readnum     = '0;
    writenum    = '0;
    write       = 1'b0;
    loada       = 1'b0;
    loadb       = 1'b0;
    loadc       = 1'b0;
    loads       = 1'b0;
    asel        = 1'b0;
    bsel        = 1'b0;
    vsel        = 1'b0;
    shift       = '0;
    ALUop       = '0;
    datapath_in = '0;
    unique case (state_q)
      WAIT: w = 1'b1;
      WRITE_IMM: begin
        writenum    = rn;
        write       = 1'b1;
        vsel        = 1'b1;
        datapath_in = imm16;
      end
      GET_A: begin
        readnum = rn;
        loada   = 1'b1;
      end
      GET_B: begin
        readnum = rm;
        loadb   = 1'b1;
      end
      EXEC: begin
        shift = sh;
        bsel  = 1'b0;
        if (is_mov_reg) begin
          asel  = 1'b1;
          ALUop = OP_MOV_REG;
        end else begin
          asel  = 1'b0;
          ALUop = op;
        end
        loads = is_cmp;
        loadc = is_alu_wr || is_mov_reg;
      end
      WRITE_REG: begin
        writenum = rd;
        write    = 1'b1;
        vsel     = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dp_controller.sv
// Self-checking bench for dp_controller: instruction vector table with a per-cycle scoreboard.
module tb_dp_controller;

  typedef struct packed {
    logic        w;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic        write;
    logic        loada;
    logic        loadb;
    logic        loadc;
    logic        loads;
    logic        asel;
    logic        bsel;
    logic        vsel;
    logic [1:0]  shift;
    logic [1:0]  aluop;
    logic [15:0] din;
  } ctrl_t;

  typedef struct {
    string          name;
    logic [15:0]    instr;
    bit             hold_s;
    int             n;
    ctrl_t [5:0]    exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        s_i;
  logic        load_i;
  logic [15:0] in_i;
  logic        w;
  logic [2:0]  readnum, writenum;
  logic        write, loada, loadb, loadc, loads, asel, bsel, vsel;
  logic [1:0]  shift, aluop;
  logic [15:0] datapath_in;

  ctrl_t act;
  ctrl_t sb[$];
  int    tests = 0;
  int    fails = 0;
  vec_t  vecs[11];

  dp_controller dut (
    .clk         (clk),
    .reset       (reset),
    .s           (s_i),
    .load        (load_i),
    .in          (in_i),
    .w           (w),
    .readnum     (readnum),
    .writenum    (writenum),
    .write       (write),
    .loada       (loada),
    .loadb       (loadb),
    .loadc       (loadc),
    .loads       (loads),
    .asel        (asel),
    .bsel        (bsel),
    .vsel        (vsel),
    .shift       (shift),
    .ALUop       (aluop),
    .datapath_in (datapath_in)
  );

  always #5 clk = ~clk;

  always_comb begin
    act.w        = w;
    act.readnum  = readnum;
    act.writenum = writenum;
    act.write    = write;
    act.loada    = loada;
    act.loadb    = loadb;
    act.loadc    = loadc;
    act.loads    = loads;
    act.asel     = asel;
    act.bsel     = bsel;
    act.vsel     = vsel;
    act.shift    = shift;
    act.aluop    = aluop;
    act.din      = datapath_in;
  end

  function automatic ctrl_t idle();
    ctrl_t c = '0;
    c.w = 1'b1;
    return c;
  endfunction

  function automatic ctrl_t dec();
    return '0;
  endfunction

  function automatic ctrl_t wimm(input logic [2:0] wn, input logic [15:0] d);
    ctrl_t c = '0;
    c.writenum = wn; c.write = 1'b1; c.vsel = 1'b1; c.din = d;
    return c;
  endfunction

  function automatic ctrl_t geta(input logic [2:0] rn);
    ctrl_t c = '0;
    c.readnum = rn; c.loada = 1'b1;
    return c;
  endfunction

  function automatic ctrl_t getb(input logic [2:0] rm);
    ctrl_t c = '0;
    c.readnum = rm; c.loadb = 1'b1;
    return c;
  endfunction

  function automatic ctrl_t exec(input logic [1:0] sh, input logic [1:0] alu,
                                 input logic as, input logic cmp);
    ctrl_t c = '0;
    c.shift = sh; c.aluop = alu; c.asel = as;
    if (cmp) c.loads = 1'b1;
    else     c.loadc = 1'b1;
    return c;
  endfunction

  function automatic ctrl_t wreg(input logic [2:0] wn);
    ctrl_t c = '0;
    c.writenum = wn; c.write = 1'b1;
    return c;
  endfunction

  function automatic vec_t mk(input string nm, input logic [15:0] ins, input bit h, input int n,
                              input ctrl_t e0, input ctrl_t e1, input ctrl_t e2,
                              input ctrl_t e3, input ctrl_t e4, input ctrl_t e5);
    vec_t v;
    v.name = nm; v.instr = ins; v.hold_s = h; v.n = n;
    v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2;
    v.exp[3] = e3; v.exp[4] = e4; v.exp[5] = e5;
    return v;
  endfunction

  task automatic check(input string name, input ctrl_t got, input ctrl_t want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // Load the instruction, pulse (or hold) s, then compare one scoreboard entry per cycle
  task automatic run_vec(input vec_t v);
    in_i   = v.instr;
    load_i = 1'b1;
    @(posedge clk); #1;
    load_i = 1'b0;
    check({v.name, "_loaded"}, act, idle());
    for (int k = 0; k < v.n; k++) sb.push_back(v.exp[k]);
    s_i = 1'b1;
    for (int k = 0; k < v.n; k++) begin
      @(posedge clk); #1;
      if (!v.hold_s) s_i = 1'b0;
      check($sformatf("%s_c%0d", v.name, k), act, sb.pop_front());
    end
    s_i = 1'b0;
    @(posedge clk); #1;
    check({v.name, "_stay"}, act, idle());
  endtask

  initial begin
    vecs[0]  = mk("mov_r0_7",   16'hD007, 1'b0, 3, dec(), wimm(3'd0, 16'h0007), idle(), idle(), idle(), idle());
    vecs[1]  = mk("mov_r1_m7",  16'hD1F9, 1'b0, 3, dec(), wimm(3'd1, 16'hFFF9), idle(), idle(), idle(), idle());
    vecs[2]  = mk("mov_r2_m128",16'hD280, 1'b0, 3, dec(), wimm(3'd2, 16'hFF80), idle(), idle(), idle(), idle());
    vecs[3]  = mk("mov_r3_127", 16'hD37F, 1'b0, 3, dec(), wimm(3'd3, 16'h007F), idle(), idle(), idle(), idle());
    vecs[4]  = mk("add_hold_s", 16'hA148, 1'b1, 6, dec(), geta(3'd1), getb(3'd0),
                  exec(2'b01, 2'b00, 1'b0, 1'b0), wreg(3'd2), idle());
    vecs[5]  = mk("cmp_r1_r0",  16'hA900, 1'b0, 5, dec(), geta(3'd1), getb(3'd0),
                  exec(2'b00, 2'b01, 1'b0, 1'b1), idle(), idle());
    vecs[6]  = mk("mov_r5_r3",  16'hC0A3, 1'b0, 5, dec(), getb(3'd3),
                  exec(2'b00, 2'b00, 1'b1, 1'b0), wreg(3'd5), idle(), idle());
    vecs[7]  = mk("and_r3",     16'hB274, 1'b0, 6, dec(), geta(3'd2), getb(3'd4),
                  exec(2'b10, 2'b10, 1'b0, 1'b0), wreg(3'd3), idle());
    vecs[8]  = mk("mvn_r7",     16'hB8F9, 1'b0, 6, dec(), geta(3'd0), getb(3'd1),
                  exec(2'b11, 2'b11, 1'b0, 1'b0), wreg(3'd7), idle());
    vecs[9]  = mk("illegal_e0", 16'hE000, 1'b1, 2, dec(), idle(), idle(), idle(), idle(), idle());
    vecs[10] = mk("mov_op01",   16'hC800, 1'b0, 2, dec(), idle(), idle(), idle(), idle(), idle());

    reset  = 1'b1;
    s_i    = 1'b0;
    load_i = 1'b0;
    in_i   = '0;
    #3;
    check("reset_state", act, idle());
    @(posedge clk); #1;
    reset = 1'b0;
    check("after_release", act, idle());

    foreach (vecs[i]) run_vec(vecs[i]);

    // Asynchronous reset in the middle of EXEC, then confirm IR was cleared
    in_i   = 16'hA148;
    load_i = 1'b1;
    @(posedge clk); #1;
    load_i = 1'b0;
    s_i    = 1'b1;
    @(posedge clk); #1;
    s_i = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_reset_exec", act, exec(2'b01, 2'b00, 1'b0, 1'b0));
    #2;
    reset = 1'b1;
    #1;
    check("reset_mid_exec", act, idle());
    @(posedge clk); #1;
    check("reset_held", act, idle());
    reset = 1'b0;
    @(posedge clk); #1;
    check("first_cycle_after_release", act, idle());
    s_i = 1'b1;
    @(posedge clk); #1;
    s_i = 1'b0;
    check("ir_cleared_decode", act, dec());
    @(posedge clk); #1;
    check("ir_cleared_back_to_wait", act, idle());

    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dp_controller.md
DP_CONTROLLER -- requirements
Module: dp_controller

Interface
REQ-001 Port clk, input, 1 bit: single rising-edge clock for all state.
REQ-002 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 Port s, input, 1 bit: start the instruction held in IR.
REQ-004 Port load, input, 1 bit: capture in into IR on the next edge.
REQ-005 Port in, input, 16 bits: instruction word.
REQ-006 Port w, output, 1 bit: high only in WAIT (controller idle).
REQ-007 Datapath control outputs SHALL be:
- readnum[2:0], writenum[2:0], write
- loada, loadb, loadc, loads
- asel, bsel, vsel
- shift[1:0], ALUop[1:0]
- datapath_in[15:0]
REQ-008 asel=0 SHALL select A; asel=1 SHALL select zero. bsel=0 SHALL select shifter output. vsel=1 SHALL select datapath_in; vsel=0 SHALL select C.

Function
REQ-009 IR (16 b) SHALL load in when load=1, in any state; IR fields SHALL be:
- opcode=IR[15:13], op=IR[12:11]
- Rn=IR[10:8], Rd=IR[7:5]
- sh=IR[4:3], Rm=IR[2:0], imm8=IR[7:0]
REQ-010 States SHALL be WAIT, DECODE, WRITE_IMM, GET_A, GET_B, EXEC, WRITE_REG; each state SHALL last exactly one cycle except WAIT.
REQ-011 WAIT: w=1; s=1 -> DECODE; otherwise remain in WAIT. s SHALL be ignored in every other state.
REQ-012 DECODE transitions:
- opcode 110, op 10 (MOV imm) -> WRITE_IMM
- opcode 110, op 00 (MOV reg) -> GET_B
- opcode 101, any op (ADD/CMP/AND/MVN) -> GET_A
- any other encoding -> WAIT, with no register write
REQ-013 WRITE_IMM: writenum=Rn, write=1, vsel=1, datapath_in=imm8 sign-extended to 16 b; next state WAIT.
REQ-014 GET_A: readnum=Rn, loada=1; next state GET_B.
REQ-015 GET_B: readnum=Rm, loadb=1; next state EXEC.
REQ-016 EXEC: shift=sh, bsel=0.
- ALU ops: asel=0, ALUop=op.
- MOV reg: asel=1, ALUop=00.
- CMP: loads=1, loadc=0, next state WAIT.
- All others: loadc=1, loads=0, next state WRITE_REG.
REQ-017 WRITE_REG: writenum=Rd, write=1, vsel=0; next state WAIT.
REQ-018 Any control output not driven by the current state SHALL be 0. These outputs SHALL be decoded combinationally from the registered state and IR (Moore).
REQ-019 Cycles from the s-sampling edge back to WAIT SHALL be:
- MOV imm: 2
- MOV reg: 4
- CMP: 4
- ADD/AND/MVN: 5
REQ-020 load=1 during execution SHALL update IR immediately. Software SHALL load only while w=1; the controller SHALL NOT guard against a mid-instruction load.

Reset
REQ-021 reset=1 SHALL force state WAIT and IR=0 immediately, independent of clk, including mid-instruction.
REQ-022 During reset, w SHALL be 1 and all other outputs SHALL be 0. No write SHALL occur in the first cycle after release.

Structure
REQ-023 A shared package dp_ctrl_pkg SHALL hold:
- the state encoding
- opcode constants (3'b110, 3'b101)
- op constants (MOV_IMM=2'b10, MOV_REG=2'b00, ADD=00, CMP=01, AND=10, MVN=11)
REQ-024 One sub-module, instr_dec, SHALL be combinational and SHALL split IR into fields plus the sign-extended imm8.

Verification
REQ-025 Reset mid-EXEC -> w=1, write=0, loadc=0 before the next clk edge.
REQ-026 load 16'hD007 (MOV R0,#7), pulse s -> one cycle with write=1, writenum=0, vsel=1, datapath_in=16'h0007; w=1 two cycles after s.
REQ-027 load 16'hD1F9 (MOV R1,#-7) -> datapath_in=16'hFFF9, writenum=1.
REQ-028 load 16'hA148 (ADD R2,R1,R0,LSL#1) -> the following sequence, each for one cycle:
- loada with readnum=1
- loadb with readnum=0
- loadc with shift=01, ALUop=00
- write with writenum=2, vsel=0
REQ-029 load 16'hA900 (CMP R1,R0) -> loads=1 in EXEC, write never asserted, w=1 four cycles after s.
REQ-030 load 16'hE000 (illegal opcode), pulse s -> DECODE then WAIT; no load/write strobe; s held high in non-WAIT states has no effect.
